// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter:
// FSM state encoding and the packet source-header format.
package uart_pkg;

    typedef logic [1:0] st_t;

    localparam st_t ST_IDLE = 2'd0;
    localparam st_t ST_HDR  = 2'd1;
    localparam st_t ST_DATA = 2'd2;

    // Header byte: tag nibble on top, requester index below.
    function automatic logic [7:0] hdr_byte(
        input logic [3:0] tag,
        input logic [3:0] id
    );
        return {tag, id};
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin priority search: first valid index at or
// above rr_ptr, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [3:0]       rr_ptr,
    output logic [3:0]       grant,
    output logic             any_valid
);

    // Walk offsets from farthest to nearest so the nearest valid wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        any_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            for (int i = 0; i < N_REQ; i++) begin
                if (i == idx && valid[i]) begin
                    grant     = 4'(i);
                    any_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-atomic round-robin arbiter feeding one UART TX FIFO,
// optionally prefixing each packet with a source header byte.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int         N_REQ   = 4,
    parameter bit         HDR_EN  = 1'b1,
    parameter logic [3:0] HDR_TAG = 4'hA
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data_in,
    output logic               tx_wr_en,
    input  logic               tx_full,
    output logic               busy,
    output logic [3:0]         gnt_id,
    output logic               pkt_done
);

    st_t        state;
    st_t        state_nxt;
    logic [3:0] rr_ptr;
    logic [3:0] rr_ptr_nxt;
    logic [3:0] pick_id;
    logic       any_valid;
    logic       sel_valid;
    logic       sel_last;
    logic [7:0] sel_data;
    logic       last_wr;

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .valid    (req_valid),
        .rr_ptr   (rr_ptr),
        .grant    (pick_id),
        .any_valid(any_valid)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_id == 4'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    assign last_wr    = (state == ST_DATA) && tx_wr_en && sel_last;
    assign rr_ptr_nxt = (gnt_id == 4'(N_REQ - 1)) ? 4'd0 : gnt_id + 4'd1;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (any_valid) begin
                    state_nxt = HDR_EN ? ST_HDR : ST_DATA;
                end
            end
            ST_HDR: begin
                if (!tx_full) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_wr) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reset low masks every strobe regardless of the current state.
    always_comb begin
        req_ready  = '0;
        tx_wr_en   = 1'b0;
        tx_data_in = '0;
        unique case (state)
            ST_HDR: begin
                tx_data_in = hdr_byte(HDR_TAG, gnt_id);
                tx_wr_en   = !tx_full;
            end
            ST_DATA: begin
                tx_data_in = sel_data;
                tx_wr_en   = sel_valid && !tx_full;
                for (int i = 0; i < N_REQ; i++) begin
                    req_ready[i] = (gnt_id == 4'(i)) && !tx_full;
                end
            end
            default: ;
        endcase
        if (!rst) begin
            tx_wr_en  = 1'b0;
            req_ready = '0;
        end
    end

    // Grant is latched in IDLE and cleared once the packet completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt_id   <= '0;
            rr_ptr   <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= last_wr;
            if (state == ST_IDLE && any_valid) begin
                gnt_id <= pick_id;
            end else if (last_wr) begin
                gnt_id <= '0;
                rr_ptr <= rr_ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: one instance with headers,
// one without, sharing requester stimulus.
module tb_uart_tx_arb;

    localparam int N = 4;
    localparam logic [3:0] TAG = 4'hA;

    typedef struct packed {
        logic       hdr;
        logic [3:0] src;
        logic       last;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]     rst_v;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [8*N-1:0] req_data;
    logic           tx_full;
    logic [N-1:0]   rdy [2];
    logic [7:0]     dout [2];
    logic [3:0]     gid [2];
    logic [1:0]     wr;
    logic [1:0]     busy;
    logic [1:0]     done;

    uart_tx_arb #(.N_REQ(N), .HDR_EN(1'b1), .HDR_TAG(TAG)) u_hdr (
        .clk(clk), .rst(rst_v[0]), .req_valid(req_valid),
        .req_data(req_data), .req_last(req_last), .req_ready(rdy[0]),
        .tx_data_in(dout[0]), .tx_wr_en(wr[0]), .tx_full(tx_full),
        .busy(busy[0]), .gnt_id(gid[0]), .pkt_done(done[0])
    );

    uart_tx_arb #(.N_REQ(N), .HDR_EN(1'b0), .HDR_TAG(TAG)) u_nohdr (
        .clk(clk), .rst(rst_v[1]), .req_valid(req_valid),
        .req_data(req_data), .req_last(req_last), .req_ready(rdy[1]),
        .tx_data_in(dout[1]), .tx_wr_en(wr[1]), .tx_full(tx_full),
        .busy(busy[1]), .gnt_id(gid[1]), .pkt_done(done[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int sel = 0;
    int full_pct = 0;
    int gap_pct = 0;
    bit force_full = 1'b0;
    int c0;

    logic [8:0] rq [N][$];
    logic [8:0] mq [N][$];
    int         gap [N];
    exp_t       exp_q [2][$];
    int         mptr [2];
    bit         pend [2];
    int         wr_cyc [$];
    int         done_cyc [$];
    exp_t       e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, expv, cyc);
        end
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_v[d]) begin
                chk("rst_wr_en", int'(wr[d]), 0);
                chk("rst_ready", int'(rdy[d]), 0);
                pend[d] = 1'b0;
            end else begin
                if (pend[d] || done[d]) begin
                    chk("pkt_done", int'(done[d]), int'(pend[d]));
                    if (d == sel && done[d]) done_cyc.push_back(cyc);
                end
                pend[d] = 1'b0;
                if (tx_full) begin
                    chk("full_wr_en", int'(wr[d]), 0);
                    chk("full_ready", int'(rdy[d]), 0);
                end
                if (!busy[d]) chk("idle_gnt_id", int'(gid[d]), 0);
                if (rdy[d] != '0) begin
                    if (exp_q[d].size() == 0)
                        chk("ready_no_pkt", int'(rdy[d]), 0);
                    else if (exp_q[d][0].hdr)
                        chk("ready_in_hdr", int'(rdy[d]), 0);
                    else
                        chk("ready_sel", int'(rdy[d]),
                            1 << exp_q[d][0].src);
                end
                if (wr[d]) begin
                    if (exp_q[d].size() == 0) begin
                        chk("extra_write", int'(wr[d]), 0);
                    end else begin
                        e = exp_q[d].pop_front();
                        chk("tx_data", int'(dout[d]), int'(e.data));
                        chk("gnt_id", int'(gid[d]), int'(e.src));
                        pend[d] = e.last;
                        if (d == sel) wr_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (gap[i] > 0) begin
                gap[i]--;
                req_valid[i] = 1'b0;
            end else begin
                req_valid[i] = (rq[i].size() > 0);
            end
            if (rq[i].size() > 0) begin
                req_data[8*i +: 8] = rq[i][0][7:0];
                req_last[i]        = rq[i][0][8];
            end else begin
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        tx_full = force_full || ($urandom_range(0, 99) < full_pct);
    endtask

    task automatic step();
        logic [N-1:0] fire;
        @(negedge clk);
        fire = req_valid & ((sel == 1) ? rdy[1] : rdy[0]);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) begin
                logic [8:0] b;
                b = rq[i].pop_front();
                if (!b[8] && $urandom_range(0, 99) < gap_pct)
                    gap[i] = $urandom_range(1, 3);
            end
        end
        drive();
    endtask

    task automatic push_byte(input int r, input logic [7:0] d,
                             input logic last);
        rq[r].push_back({last, d});
        mq[r].push_back({last, d});
    endtask

    task automatic add_pkt(input int r, input int len);
        for (int k = 0; k < len; k++)
            push_byte(r, 8'($urandom), k == len - 1);
    endtask

    // Reference: serve whole packets in round-robin order of pending work.
    task automatic model_run();
        logic [8:0] b;
        int g;
        forever begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && mq[(mptr[sel] + k) % N].size() > 0)
                    g = (mptr[sel] + k) % N;
            if (g < 0) break;
            if (sel == 0)
                exp_q[0].push_back('{1'b1, 4'(g), 1'b0, {TAG, 4'(g)}});
            do begin
                b = mq[g].pop_front();
                exp_q[sel].push_back('{1'b0, 4'(g), b[8], b[7:0]});
            end while (!b[8]);
            mptr[sel] = (g + 1) % N;
        end
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            mq[i].delete();
            gap[i] = 0;
        end
        exp_q[sel].delete();
    endtask

    task automatic drain(input string name);
        int b;
        b = 0;
        while (exp_q[sel].size() > 0 && b < 3000) begin
            step();
            b++;
        end
        chk({name, "_left"}, exp_q[sel].size(), 0);
        if (exp_q[sel].size() > 0) flush();
        step();
        chk({name, "_busy_after"}, int'(busy[sel]), 0);
    endtask

    task automatic wait_writes(input int n);
        int b;
        b = 0;
        while (wr_cyc.size() < n && b < 500) begin
            step();
            b++;
        end
        chk("progress", int'(wr_cyc.size() >= n), 1);
    endtask

    task automatic rand_rounds(input int n);
        gap_pct  = 30;
        full_pct = 25;
        for (int t = 0; t < n; t++) begin
            for (int r = 0; r < N; r++) begin
                int np;
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++)
                    add_pkt(r, $urandom_range(1, 5));
            end
            model_run();
            drive();
            drain("rand");
        end
        gap_pct  = 0;
        full_pct = 0;
    endtask

    task automatic check_single(input string name, input int len);
        chk({name, "_nwr"}, wr_cyc.size(), len);
        if (wr_cyc.size() == len)
            for (int k = 0; k < len; k++)
                chk({name, "_wr_cyc"}, wr_cyc[k], c0 + 1 + k);
        chk({name, "_ndone"}, done_cyc.size(), 1);
        if (done_cyc.size() == 1)
            chk({name, "_done_cyc"}, done_cyc[0], c0 + len + 1);
    endtask

    initial begin
        rst_v     = 2'b00;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_full   = 1'b0;
        mptr[0]   = 0;
        mptr[1]   = 0;
        pend[0]   = 1'b0;
        pend[1]   = 1'b0;
        for (int i = 0; i < N; i++) gap[i] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_gnt_id", int'(gid[0]), 0);
        chk("rst_pkt_done", int'(done[0]), 0);
        chk("rst_tx_data", int'(dout[0]), 0);
        @(posedge clk);
        #1;
        rst_v = 2'b01;
        drive();
        step();

        // Single packet from requester 2, no backpressure.
        wr_cyc.delete();
        done_cyc.delete();
        c0 = cyc;
        push_byte(2, 8'h11, 1'b0);
        push_byte(2, 8'h22, 1'b0);
        push_byte(2, 8'h33, 1'b1);
        model_run();
        drive();
        drain("single");
        check_single("single", 4);

        // Contention between 0 and 3, two rounds.
        for (int round = 0; round < 2; round++) begin
            wr_cyc.delete();
            add_pkt(0, 2);
            add_pkt(3, 2);
            model_run();
            drive();
            drain("contend");
            chk("contend_nwr", wr_cyc.size(), 6);
            if (wr_cyc.size() == 6) begin
                chk("b2b_idle_gap", wr_cyc[3] - wr_cyc[2], 2);
                chk("hdr_to_data", wr_cyc[1] - wr_cyc[0], 1);
            end
        end

        // Backpressure for 5 cycles mid-packet.
        wr_cyc.delete();
        add_pkt(1, 6);
        model_run();
        drive();
        wait_writes(3);
        force_full = 1'b1;
        drive();
        c0 = wr_cyc.size();
        repeat (5) step();
        chk("bp_no_write", wr_cyc.size(), c0);
        force_full = 1'b0;
        drain("bp");

        // Granted requester stalls while another waits.
        wr_cyc.delete();
        add_pkt(1, 5);
        model_run();
        drive();
        wait_writes(2);
        add_pkt(0, 2);
        model_run();
        gap[1] = 3;
        drive();
        drain("stall");
        if (wr_cyc.size() >= 3)
            chk("stall_gap", wr_cyc[2] - wr_cyc[1], 4);

        rand_rounds(40);

        // Reset in mid-packet after rr_ptr has moved off 0.
        add_pkt(0, 2);
        model_run();
        drive();
        drain("pre_rst");
        wr_cyc.delete();
        add_pkt(2, 6);
        model_run();
        drive();
        wait_writes(3);
        rst_v[0] = 1'b0;
        step();
        step();
        flush();
        mptr[0]  = 0;
        rst_v[0] = 1'b1;
        drive();
        @(negedge clk);
        chk("post_rst_busy", int'(busy[0]), 0);
        chk("post_rst_gnt_id", int'(gid[0]), 0);
        chk("post_rst_pkt_done", int'(done[0]), 0);
        @(posedge clk);
        #1;
        add_pkt(0, 2);
        add_pkt(3, 2);
        model_run();
        drive();
        drain("post_rst");

        // Header-less instance.
        sel   = 1;
        rst_v = 2'b00;
        step();
        step();
        rst_v = 2'b10;
        drive();
        step();
        wr_cyc.delete();
        done_cyc.delete();
        c0 = cyc;
        push_byte(1, 8'h5A, 1'b0);
        push_byte(1, 8'hC3, 1'b0);
        push_byte(1, 8'h00, 1'b0);
        push_byte(1, 8'hFF, 1'b1);
        model_run();
        drive();
        drain("nohdr");
        check_single("nohdr", 4);

        rand_rounds(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Packet-atomic round-robin arbiter that shares one UART transmit path between N_REQ byte-stream requesters. Sits directly in front of `uart_top`. It drives `tx_data_in`/`tx_wr_en` and honours `tx_full`. Each packet can be preceded by a one-byte source header, so the far end can demultiplex the streams.

## Interface
Parameters:
- N_REQ, 4: number of requesters, legal range 2..16.
- HDR_EN, 1: 1 prepends a header byte to every packet; 0 sends no header.
- HDR_TAG, 4'hA: upper nibble of the header byte.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-low reset; rst=0 resets the block on the next rising clk.
- req_valid  input  N_REQ  per-requester byte valid.
- req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  N_REQ  marks the final byte of a packet.
- req_ready  output  N_REQ  byte accepted when valid and ready are both high.
- tx_data_in  output  8  byte to the UART TX FIFO.
- tx_wr_en  output  1  write strobe to the UART TX FIFO.
- tx_full  input  1  UART TX FIFO full.
- busy  output  1  high when the state is not IDLE.
- gnt_id  output  4  index of the granted requester; 0 when idle.
- pkt_done  output  1  one-cycle pulse when the last byte of a packet is written.

## Operation
- FSM states are IDLE, HDR and DATA.
- IDLE:
  - If any req_valid is high, grant the first valid index found searching from rr_ptr upward, wrapping modulo N_REQ.
  - Latch that index into gnt_id.
  - Go to HDR if HDR_EN=1, otherwise go to DATA.
  - No byte is written in IDLE.
- HDR:
  - tx_data_in = {HDR_TAG, gnt_id}.
  - tx_wr_en = ~tx_full.
  - When the write occurs, go to DATA. If tx_full is high, stay in HDR.
- DATA:
  - req_ready[gnt_id] = ~tx_full. All other ready bits are 0.
  - tx_data_in = req_data of gnt_id.
  - tx_wr_en = req_valid[gnt_id] & ~tx_full.
  - On a write with req_last[gnt_id]=1:
    - pulse pkt_done on the next cycle (registered);
    - set rr_ptr = (gnt_id+1) mod N_REQ;
    - go to IDLE.
- The grant is held for the whole packet. Other requesters see ready=0 and are never interleaved, whatever their valid state.
- Gaps in req_valid[gnt_id] during DATA are legal. The block waits with no write.
- tx_wr_en and req_ready are combinational from state, gnt_id, req_valid and tx_full. tx_full must therefore be a registered FIFO flag, which `uart_fifo` already provides.
- Reset values: state=IDLE, rr_ptr=0, gnt_id=0, busy=0, pkt_done=0, tx_wr_en=0, req_ready=0, tx_data_in=8'h00.
- While rst=0, tx_wr_en and req_ready are forced to 0 combinationally.
- Reset in the middle of a packet abandons it. Bytes already written stay in the FIFO, and no pkt_done is issued.

## Timing
- A requester asserting valid in IDLE gets its grant on the next edge:
  - the header write occurs in the cycle after the grant;
  - the first data byte can be written the cycle after that.
- A packet of L bytes with no backpressure takes 1 (IDLE) + HDR_EN + L cycles.
- Throughput in DATA is 1 byte/clk while ~tx_full and valid are high.
- Back-to-back packets have one IDLE cycle between them.
- pkt_done is high on the cycle after the last write, coinciding with IDLE.
- Simultaneous events:
  - A last-byte write and a new valid from another requester in the same cycle: the new requester is evaluated in the following IDLE cycle using the updated rr_ptr.
  - tx_full rising in the same cycle as a last byte: no write occurs, and the block stays in DATA.
- A single-byte packet (valid and last on the first byte) is legal: IDLE → HDR → DATA → IDLE.

## Structure
- Shared package `uart_pkg`:
  - state encoding localparams ST_IDLE, ST_HDR, ST_DATA;
  - the header-byte format function hdr_byte(tag, id).
- One sub-module, `rr_pick`: a combinational round-robin priority search with inputs valid vector and rr_ptr, and outputs grant index and any_valid.
- The FSM, rr_ptr, gnt_id and output muxing live in `uart_tx_arb`.

## Test plan
- Single packet:
  - Stimulus: N_REQ=4, HDR_EN=1, requester 2 sends 8'h11, 8'h22, 8'h33 with last on 8'h33, tx_full=0.
  - Required: FIFO writes are 8'hA2, 8'h11, 8'h22, 8'h33 on consecutive cycles; pkt_done one cycle later; busy=0 afterwards.
- Contention:
  - Stimulus: requesters 0 and 3 both valid with 2-byte packets, starting from reset (rr_ptr=0).
  - Required: the packet from 0 (8'hA0, ...) is sent complete, then the packet from 3 (8'hA3, ...), with no interleaving.
  - Required: a second round with both valid again grants 0 first, because rr_ptr wrapped to 0 after 3 was served.
- Backpressure:
  - Stimulus: tx_full held high for 5 cycles mid-packet.
  - Required: tx_wr_en=0 and req_ready=0 during those cycles; no byte lost or duplicated.
- Stalled requester:
  - Stimulus: requester 1's valid drops for 3 cycles mid-packet while requester 0 is valid.
  - Required: the grant stays with 1, and req_ready[0] stays 0 until 1's last byte.
- Header disabled:
  - Stimulus: HDR_EN=0.
  - Required: only payload bytes are written, and the cycle count per packet is 1+L.
- Mid-packet reset:
  - Stimulus: rst=0 asserted during DATA.
  - Required: tx_wr_en=0 during rst=0; next cycle state=IDLE, gnt_id=0, rr_ptr=0, no pkt_done pulse.
